mux4_way_16: RTL and testbench

- 4-input, WIDTH-bit word selector for the Hack datapath.
- The combinational output y follows the 2-bit select with zero latency.
- A registered copy (y_q, sel_q, out_valid) is provided for pipelined consumers.
- A saturating select-change counter is provided for debug and coverage.

---
 rtl/mux4_way_16.sv | 80 ++++++++
 tb/tb_mux4_way_16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_way_16.sv
// mux4_way_16: 4-input WIDTH-bit word selector with a registered copy of the
// selected word and a saturating select-change counter.
// Optional macro MUX4WAY16_PARITY_EN adds y_par (registered XOR-reduce of
// y_q) and y_par_comb (XOR-reduce of y).
module mux4_way_16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_changes
`ifdef MUX4WAY16_PARITY_EN
    ,
    output logic             y_par,
    output logic             y_par_comb
`endif
);

    logic [1:0] sel_prev;

    // Zero-latency word select; an unknown select propagates X.
    always_comb begin
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            2'b11:   y = d;
            default: y = 'x;
        endcase
    end

    // Registered copy of the selected word, qualified by in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            sel_q     <= 2'b00;
            out_valid <= 1'b0;
`ifdef MUX4WAY16_PARITY_EN
            y_par     <= 1'b0;
`endif
        end else if (in_valid) begin
            y_q       <= y;
            sel_q     <= sel;
            out_valid <= 1'b1;
`ifdef MUX4WAY16_PARITY_EN
            y_par     <= ^y;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of select transitions, independent of in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_prev    <= 2'b00;
            sel_changes <= '0;
        end else begin
            sel_prev <= sel;
            if ((sel != sel_prev) && (sel_changes != '1)) begin
                sel_changes <= sel_changes + 1'b1;
            end
        end
    end

`ifdef MUX4WAY16_PARITY_EN
    assign y_par_comb = ^y;
`endif

endmodule

// File: tb/tb_mux4_way_16.sv
// Self-checking bench for mux4_way_16: directed test-plan sequences followed
// by randomized stimulus, all compared against a behavioural reference model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_mux4_way_16;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a, b, c, d;
    logic [1:0]       sel;
    logic             in_valid;

    logic [WIDTH-1:0] y, y_q, y2, y_q2;
    logic [1:0]       sel_q, sel_q2;
    logic             out_valid, out_valid2;
    logic [15:0]      sel_changes;
    logic [1:0]       sel_changes2;
`ifdef MUX4WAY16_PARITY_EN
    logic             y_par, y_par_comb, y_par2, y_par_comb2;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    // reference model state
    logic [WIDTH-1:0] m_yq;
    logic [1:0]       m_selq;
    logic             m_ov;
    logic [1:0]       m_prev;
    int unsigned      m_cnt;
    int unsigned      m_cnt2;

    mux4_way_16 #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .sel(sel),
        .in_valid(in_valid), .y(y), .y_q(y_q), .sel_q(sel_q),
        .out_valid(out_valid), .sel_changes(sel_changes)
`ifdef MUX4WAY16_PARITY_EN
        , .y_par(y_par), .y_par_comb(y_par_comb)
`endif
    );

    mux4_way_16 #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .sel(sel),
        .in_valid(in_valid), .y(y2), .y_q(y_q2), .sel_q(sel_q2),
        .out_valid(out_valid2), .sel_changes(sel_changes2)
`ifdef MUX4WAY16_PARITY_EN
        , .y_par(y_par2), .y_par_comb(y_par_comb2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] s);
        logic [WIDTH-1:0] words [4];
        words[0] = a;
        words[1] = b;
        words[2] = c;
        words[3] = d;
        return words[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
                     observed, expected, $time);
        end
    endtask

    // Reference model: inputs only change on negedge, so they are stable here.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_yq   = '0;
            m_selq = 2'b00;
            m_ov   = 1'b0;
            m_prev = 2'b00;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (in_valid) begin
                m_yq   = pick(sel);
                m_selq = sel;
                m_ov   = 1'b1;
            end else begin
                m_ov   = 1'b0;
            end
            if (sel != m_prev) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_prev = sel;
        end
    end

    task automatic check_comb();
        check("y", 32'(y), 32'(pick(sel)));
        check("y_sat", 32'(y2), 32'(pick(sel)));
`ifdef MUX4WAY16_PARITY_EN
        check("y_par_comb", 32'(y_par_comb), 32'(^pick(sel)));
`endif
    endtask

    task automatic check_regs();
        check("y_q", 32'(y_q), 32'(m_yq));
        check("sel_q", 32'(sel_q), 32'(m_selq));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("sel_changes", 32'(sel_changes), m_cnt);
        check("sel_changes_sat", 32'(sel_changes2), m_cnt2);
`ifdef MUX4WAY16_PARITY_EN
        check("y_par", 32'(y_par), 32'(^m_yq));
`endif
    endtask

    // one clock: apply inputs at negedge, check comb, then registered state
    task automatic cycle(input logic r, input logic v, input logic [1:0] s);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        sel      = s;
        #1 check_comb();
        @(posedge clk);
        #1 check_regs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        sel         = 2'b00;
        a = 16'h0001; b = 16'h0002; c = 16'h0004; d = 16'h0008;

        // combinational select, no clock edge between change and check
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = 2'(i);
            #1 check("y_step", 32'(y), 32'(16'h0001 << i));
        end

        // reset dominates in_valid and sel
        cycle(1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b1, 2'b11);
        check("rst_y_q", 32'(y_q), 32'h0);
        check("rst_cnt", 32'(sel_changes), 32'h0);
        check("rst_y", 32'(y), 32'h0008);

        // capture then hold
        cycle(1'b1, 1'b1, 2'b10);
        check("cap_y_q", 32'(y_q), 32'h0004);
        check("cap_sel_q", 32'(sel_q), 32'h2);
        check("cap_ov", 32'(out_valid), 32'h1);
        cycle(1'b1, 1'b0, 2'b01);
        check("hold_y_q", 32'(y_q), 32'h0004);
        check("hold_ov", 32'(out_valid), 32'h0);
        check("hold_y", 32'(y), 32'h0002);

        // sel=11 right after reset counts once
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 2'b11);
        check("first_after_rst", 32'(sel_changes), 32'h1);

        // 00->01->10->11->00 after reset gives 4, then hold
        cycle(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 2'(i));
        check("cycle4", 32'(sel_changes), 32'h4);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 2'b00);
        check("hold_cnt", 32'(sel_changes), 32'h4);
        check("sat_cnt", 32'(sel_changes2), 32'h3);

`ifdef MUX4WAY16_PARITY_EN
        cycle(1'b1, 1'b1, 2'b11);
        check("par_d8", 32'(y_par), 32'h1);
        a = 16'h0003;
        cycle(1'b1, 1'b1, 2'b00);
        check("par_a3", 32'(y_par), 32'h0);
`endif

        // randomized traffic with occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            d = 16'($urandom);
            cycle(($urandom_range(0, 29) != 0), 1'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
